// File: rtl/ram_8x8_if.sv
// Bus interface for the ram_8x8 single-port RAM: write select, shared address,
// write data and registered read data.
interface ram_8x8_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output wr,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  wr,
        input  addr,
        input  din,
        output dout
    );
endinterface

// File: rtl/ram_8x8.sv
// Single-port synchronous RAM with registered read data and synchronous clear.
// Optional macro RAM_WRITE_THROUGH_EN: a write cycle also loads din into dout.
module ram_8x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ram_8x8_if.slave   bus
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] dout_r;

    // Memory array: reset clears every word in one edge, otherwise write on wr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (bus.wr) begin
            mem_r[bus.addr] <= bus.din;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Read data register: loads on read cycles, write cycles hold or pass din.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_r <= {DATA_WIDTH{1'b0}};
        end else if (bus.wr) begin
`ifdef RAM_WRITE_THROUGH_EN
            dout_r <= bus.din;
`else
            dout_r <= dout_r;
`endif
        end else begin
            dout_r <= mem_r[bus.addr];
        end
    end

    assign bus.dout = dout_r;
endmodule

// File: tb/tb_ram_8x8.sv
// Self-checking bench for ram_8x8: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_ram_8x8;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    logic [7:0] model_mem [8];
    logic [7:0] model_dout;

    ram_8x8_if bus ();

    ram_8x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs at the falling edge, apply the edge, update the model.
    task automatic cycle(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        rst_n    = r;
        bus.wr   = w;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
            model_dout = 8'h00;
        end else if (w) begin
            model_mem[a] = d;
`ifdef RAM_WRITE_THROUGH_EN
            model_dout = d;
`endif
        end else begin
            model_dout = model_mem[a];
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 3'd0, 8'h00);
        cycle(1'b0, 1'b1, 3'd4, 8'hEE);
        n_cmp++;
        if (bus.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dout: got %h expected %h", bus.dout, 8'h00);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 3'(i), 8'h00);
            n_cmp++;
            if (bus.dout !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h expected %h", i, bus.dout, 8'h00);
            end
        end
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3'(i), 8'(i * 8));
    endtask

    task automatic test_fill_readback();
        fill();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 3'(i), 8'h00);
            n_cmp++;
            if (bus.dout !== 8'(i * 8)) begin
                n_fail++;
                $display("FAIL fill_read[%0d]: got %h expected %h", i, bus.dout, 8'(i * 8));
            end
        end
    endtask

    task automatic test_overwrite();
        cycle(1'b1, 1'b1, 3'd3, 8'hA5);
        cycle(1'b1, 1'b1, 3'd3, 8'h5A);
        cycle(1'b1, 1'b0, 3'd3, 8'h00);
        n_cmp++;
        if (bus.dout !== 8'h5A) begin
            n_fail++;
            $display("FAIL overwrite_addr3: got %h expected %h", bus.dout, 8'h5A);
        end
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                cycle(1'b1, 1'b0, 3'(i), 8'h00);
                n_cmp++;
                if (bus.dout !== 8'(i * 8)) begin
                    n_fail++;
                    $display("FAIL overwrite_other[%0d]: got %h expected %h", i, bus.dout, 8'(i * 8));
                end
            end
        end
    endtask

    task automatic test_write_cycle_dout();
        logic [7:0] exp_v;
        cycle(1'b1, 1'b0, 3'd2, 8'h00);
        n_cmp++;
        if (bus.dout !== 8'd16) begin
            n_fail++;
            $display("FAIL wcyc_read2: got %h expected %h", bus.dout, 8'd16);
        end
        cycle(1'b1, 1'b1, 3'd6, 8'hFF);
`ifdef RAM_WRITE_THROUGH_EN
        exp_v = 8'hFF;
`else
        exp_v = 8'd16;
`endif
        n_cmp++;
        if (bus.dout !== exp_v) begin
            n_fail++;
            $display("FAIL wcyc_dout: got %h expected %h", bus.dout, exp_v);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.dout !== exp_v) begin
            n_fail++;
            $display("FAIL wcyc_hold_between_edges: got %h expected %h", bus.dout, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        fill();
        cycle(1'b0, 1'b1, 3'd7, 8'h77);
        cycle(1'b1, 1'b0, 3'd7, 8'h00);
        n_cmp++;
        if (bus.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_addr7: got %h expected %h", bus.dout, 8'h00);
        end
    endtask

    task automatic test_write_then_read();
        cycle(1'b1, 1'b1, 3'd5, 8'h3C);
        cycle(1'b1, 1'b0, 3'd5, 8'h00);
        n_cmp++;
        if (bus.dout !== 8'h3C) begin
            n_fail++;
            $display("FAIL wr_then_rd_addr5: got %h expected %h", bus.dout, 8'h3C);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 31) != 0);
            w = $urandom_range(0, 1) == 1;
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            cycle(r, w, a, d);
            n_cmp++;
            if (bus.dout !== model_dout) begin
                n_fail++;
                $display("FAIL random[%0d] rst_n=%0b wr=%0b addr=%0d: got %h expected %h",
                         k, r, w, a, bus.dout, model_dout);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = 3'd0;
        bus.din  = 8'h00;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
        model_dout = 8'h00;

        test_reset();
        test_fill_readback();
        test_overwrite();
        test_write_cycle_dout();
        test_reset_mid();
        test_write_then_read();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
